mips_multicycle_control: RTL
============================

# mips_multicycle_control

Multi-cycle main control unit for the MIPS datapath. It decodes the 6-bit opcode and drives a Moore FSM that sequences the shared ULA, instruction/data memory, register file and PC muxes, so one instruction takes 3–5 clocks instead of one. It also keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- No parameters.
- `clock` in 1: single clock; all state updates occur on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instruction[31:26] from the instruction register.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if the ULA zero flag is set (beq).
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ULA out.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: register write address. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back source. 0 = ULA, 1 = memory data.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ULA A input. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ULA B input. 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ula_operation` out 2: ULA_control input. 00 = add, 01 = sub, 10 = funct field.
- `pc_source` out 2: PC source. 00 = ULA result, 01 = ULA out register, 10 = jump target.
- `state` out 4: current state encoding, for debug.
- `instr_done` out 1: high in the final cycle of every legal instruction.
- `illegal_op` out 1: sticky flag, set on an unknown opcode.
- `instr_count` out 32: count of retired instructions.

## Operation
- **States:**
  - RESET=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, ILLEGAL=13.
  - Codes 14–15 are unreachable and return to FETCH.
- **Opcodes:** R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- **Transitions:**
  - RESET→FETCH→DECODE.
  - From DECODE: lw/sw→MEM_ADDR; R→R_EXEC; beq→BRANCH; addi→ADDI_EXEC; j→JUMP; any other opcode→ILLEGAL.
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw). MEM_READ→MEM_WB.
  - R_EXEC→R_WB. ADDI_EXEC→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB and ILLEGAL all →FETCH.
- **Outputs:** Moore, decoded only from `state`. Every signal not listed for a state is 0.
  - FETCH: mem_read, ir_write, alu_src_b=01, pc_write.
  - DECODE: alu_src_b=11.
  - MEM_ADDR and ADDI_EXEC: alu_src_a, alu_src_b=10.
  - MEM_READ: mem_read, i_or_d.
  - MEM_WB: reg_write, mem_to_reg.
  - MEM_WRITE: mem_write, i_or_d.
  - R_EXEC: alu_src_a, ula_operation=10.
  - R_WB: reg_write, reg_dst.
  - ADDI_WB: reg_write.
  - BRANCH: alu_src_a, ula_operation=01, pc_write_cond, pc_source=01.
  - JUMP: pc_write, pc_source=10.
  - RESET and ILLEGAL: all zero.
- **instr_done:** 1 in MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB.
- **instr_count:** increments by 1 on each rising edge where instr_done=1. Wraps from 0xFFFFFFFF to 0.
- **illegal_op:** set on the edge leaving ILLEGAL and held until reset. Illegal instructions are not counted.
- **opcode sampling:** opcode is sampled only in DECODE and is ignored in all other states.

## Timing
- Reset values:
  - state=RESET, so every control output is 0.
  - instr_done=0, illegal_op=0, instr_count=0.
  - Reset acts immediately, asynchronously, including mid-instruction. An interrupted instruction is not counted.
- First FETCH is one cycle after reset deasserts.
- Latency in clocks, counted from FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 3.
- Outputs change only after a rising edge (plus decode delay). There are no combinational paths from `opcode` to the outputs.
- Back-to-back instructions: the cycle after any final state is FETCH. There are no idle cycles.

## Configuration
- `MIPS_CTRL_JUMP_EN` defined:
  - j (000010) is decoded to JUMP.
  - `pc_source`=10 is reachable.
- `MIPS_CTRL_JUMP_EN` undefined:
  - The JUMP state is not compiled.
  - 000010 is treated as illegal and goes DECODE→ILLEGAL.
  - `pc_source` never takes the value 10.
  - The state encoding is unchanged.

## Structure
- Shared package/include `mips_ctrl_defs`: state codes, opcode constants, ula_operation codes (ADD/SUB/FUNCT), alu_src_b and pc_source codes.
- Sub-module `mips_ctrl_decode`: purely combinational, state → control vector.
- The top holds the state register, next-state logic, instr_count and illegal_op.

## Test plan
- Reset is held for 3 cycles and then released. All outputs are 0 during reset. The cycle after release has state=1 with mem_read=ir_write=pc_write=1 and alu_src_b=01.
- Execute lw (100011) then sw (101011). Required sequence: states 1,2,3,4,5 then 1,2,3,6. instr_done pulses twice and instr_count=2.
- Execute R-type, addi and beq. R_EXEC shows ula_operation=10; BRANCH shows ula_operation=01, pc_write_cond=1 and pc_source=01. Final instr_count=3.
- Present opcode 111111 in DECODE. Required: ILLEGAL, then FETCH, illegal_op=1 (sticky), instr_count unchanged.
- Present j (000010) with the macro defined: JUMP with pc_write=1 and pc_source=10. With the macro undefined: ILLEGAL and illegal_op=1.
- Apply two directed cases:
  - Assert reset during MEM_READ: state goes to 0 immediately and instr_count goes to 0.
  - Preload instr_count to 0xFFFFFFFF through a bench force, then retire one instruction: instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_defs.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes, opcodes,
// ULA/mux select codes and the packed control vector.
package mips_ctrl_defs;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_operation;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decoder: maps the current state to the datapath control vector.
// The JUMP state decode exists only when MIPS_CTRL_JUMP_EN is defined.
module mips_ctrl_decode
  import mips_ctrl_defs::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.ula_operation = ULA_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.ula_operation = ULA_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: state register, next-state logic, retired-instruction
// counter and sticky illegal-opcode flag. Optional j support via MIPS_CTRL_JUMP_EN.
module mips_multicycle_control
  import mips_ctrl_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ula_operation,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  state_t      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        illegal_q, illegal_d;
  logic        is_store_q, is_store_d;
  ctrl_t       ctrl;

  mips_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_comb begin
    state_d       = state_q;
    instr_count_d = instr_count_q;
    illegal_d     = illegal_q;
    is_store_d    = is_store_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // lw/sw share MEM_ADDR, so the load/store choice is latched here
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef MIPS_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ILLEGAL: begin
        state_d   = S_FETCH;
        illegal_d = 1'b1;
      end
      default:     state_d = S_FETCH;
    endcase
    if (ctrl.instr_done)
      instr_count_d = instr_count_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_RESET;
      instr_count_q <= 32'd0;
      illegal_q     <= 1'b0;
      is_store_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
      is_store_q    <= is_store_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign ula_operation = ctrl.ula_operation;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign state         = state_q;
  assign illegal_op    = illegal_q;
  assign instr_count   = instr_count_q;

endmodule
